// File: rtl/rm_event_dispatcher.sv
// Runtime-monitor lane dispatcher: maps commit-group contexts onto monitor lanes and drives one-hot lane event vectors.
// Optional idle-lane expiry is compiled in with `define RM_DISPATCH_IDLE_EVICT_EN.
module rm_event_dispatcher #(
  parameter int NUM_LANES         = 5,
  parameter int NUM_EVENTS        = 10,
  parameter int NUM_MONITORED_INS = 2,
  parameter int CTX_W             = 16,
  parameter int IDLE_CYCLES       = 1024,
  parameter int EVT_W             = $clog2(NUM_EVENTS)
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             valid_i,
  output logic                                             ready_o,
  input  logic [CTX_W-1:0]                                 ctx_i,
  input  logic [NUM_MONITORED_INS-1:0]                     ins_valid_i,
  input  logic [NUM_MONITORED_INS*EVT_W-1:0]               ins_event_i,
  input  logic                                             release_valid_i,
  output logic                                             release_ready_o,
  input  logic [CTX_W-1:0]                                 release_ctx_i,
  output logic [NUM_LANES*NUM_MONITORED_INS*NUM_EVENTS-1:0] lane_vector_o,
  output logic [NUM_LANES-1:0]                             lane_reset_o,
  output logic [NUM_LANES-1:0]                             lane_ctx_valid_o,
  output logic                                             evict_o
);

  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int SLOT_BITS = NUM_MONITORED_INS * NUM_EVENTS;
  localparam int VEC_W     = NUM_LANES * SLOT_BITS;

  typedef enum logic {ST_IDLE, ST_RESET} state_t;

  state_t                           state_q, state_d;
  logic [NUM_LANES-1:0]             lane_vld_q, vld_d;
  logic [CTX_W-1:0]                 lane_tag_q [NUM_LANES];
  logic [LANE_W-1:0]                rr_q, rr_d;

  logic [LANE_W-1:0]                held_lane_p0;
  logic [NUM_MONITORED_INS-1:0]     held_ins_valid_p0;
  logic [NUM_MONITORED_INS*EVT_W-1:0] held_ins_event_p0;

  logic [VEC_W-1:0]                 vec_d;
  logic [NUM_LANES-1:0]             lrst_d;
  logic                             evict_d;
  logic                             tag_we, hold_load;
  logic [NUM_LANES-1:0]             dlv_mask, alloc_mask;

  logic                             hit, free_found, rel_hit;
  logic [LANE_W-1:0]                hit_lane, free_lane, rel_lane, victim;
  logic                             accept_grp, release_fire, grp_nonempty;

  function automatic logic [SLOT_BITS-1:0] decode_group(
    input logic [NUM_MONITORED_INS-1:0]       v,
    input logic [NUM_MONITORED_INS*EVT_W-1:0] e
  );
    logic [SLOT_BITS-1:0] r;
    logic [EVT_W-1:0]     idx;
    r = '0;
    for (int k = 0; k < NUM_MONITORED_INS; k++) begin
      idx = e[k*EVT_W +: EVT_W];
      if (v[k] && (int'(idx) < NUM_EVENTS))
        r[k*NUM_EVENTS + int'(idx)] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] place_on_lane(
    input logic [LANE_W-1:0]    lane,
    input logic [SLOT_BITS-1:0] slots
  );
    logic [VEC_W-1:0] v;
    v = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (lane == LANE_W'(l)) v[l*SLOT_BITS +: SLOT_BITS] = slots;
    return v;
  endfunction

  assign ready_o          = (state_q == ST_IDLE) && !release_valid_i && !rst_i;
  assign release_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign accept_grp       = valid_i && ready_o;
  assign release_fire     = release_valid_i && release_ready_o;
  assign grp_nonempty     = |ins_valid_i;
  assign lane_ctx_valid_o = lane_vld_q;

  // Lane table lookup: context hit, release hit, lowest free lane
  always_comb begin
    hit        = 1'b0;
    hit_lane   = '0;
    rel_hit    = 1'b0;
    rel_lane   = '0;
    free_found = 1'b0;
    free_lane  = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (lane_vld_q[l] && (lane_tag_q[l] == ctx_i)) begin
        hit      = 1'b1;
        hit_lane = LANE_W'(l);
      end
      if (lane_vld_q[l] && (lane_tag_q[l] == release_ctx_i)) begin
        rel_hit  = 1'b1;
        rel_lane = LANE_W'(l);
      end
      if (!lane_vld_q[l]) begin
        free_found = 1'b1;
        free_lane  = LANE_W'(l);
      end
    end
    victim = free_found ? free_lane : rr_q;
  end

`ifdef RM_DISPATCH_IDLE_EVICT_EN
  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt_q [NUM_LANES];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(IDLE_CYCLES)) ? CNT_W'(IDLE_CYCLES) : c + 1'b1;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    vld_d      = lane_vld_q;
    rr_d       = rr_q;
    vec_d      = '0;
    lrst_d     = '0;
    evict_d    = 1'b0;
    tag_we     = 1'b0;
    hold_load  = 1'b0;
    dlv_mask   = '0;
    alloc_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (release_fire) begin
          if (rel_hit) begin
            vld_d[rel_lane]  = 1'b0;
            lrst_d[rel_lane] = 1'b1;
          end
        end else if (accept_grp && grp_nonempty) begin
          if (hit) begin
            vec_d              = place_on_lane(hit_lane, decode_group(ins_valid_i, ins_event_i));
            dlv_mask[hit_lane] = 1'b1;
          end else begin
            vld_d[victim]      = 1'b1;
            lrst_d[victim]     = 1'b1;
            alloc_mask[victim] = 1'b1;
            tag_we             = 1'b1;
            hold_load          = 1'b1;
            state_d            = ST_RESET;
            if (!free_found) begin
              evict_d = 1'b1;
              rr_d    = (rr_q == LANE_W'(NUM_LANES - 1)) ? '0 : rr_q + 1'b1;
            end
          end
        end
      end
      ST_RESET: begin
        vec_d                  = place_on_lane(held_lane_p0, decode_group(held_ins_valid_p0, held_ins_event_p0));
        dlv_mask[held_lane_p0] = 1'b1;
        state_d                = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef RM_DISPATCH_IDLE_EVICT_EN
    // Idle expiry; lanes being fed or (re)allocated this cycle are spared
    if (state_q == ST_IDLE) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_vld_q[l] && (idle_cnt_q[l] == CNT_W'(IDLE_CYCLES)) && !dlv_mask[l] && !alloc_mask[l]) begin
          vld_d[l]  = 1'b0;
          lrst_d[l] = 1'b1;
        end
      end
    end
`endif
  end

  // Stage p1: registered control and lane outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      lane_vld_q    <= '0;
      rr_q          <= '0;
      lane_vector_o <= '0;
      lane_reset_o  <= '0;
      evict_o       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_vld_q    <= vld_d;
      rr_q          <= rr_d;
      lane_vector_o <= vec_d;
      lane_reset_o  <= lrst_d;
      evict_o       <= evict_d;
    end
  end

  // Stage p0: tag store and one-entry held-group buffer (data only, no reset)
  always_ff @(posedge clk_i) begin
    if (tag_we) lane_tag_q[victim] <= ctx_i;
    if (hold_load) begin
      held_lane_p0      <= victim;
      held_ins_valid_p0 <= ins_valid_i;
      held_ins_event_p0 <= ins_event_i;
    end
  end

`ifdef RM_DISPATCH_IDLE_EVICT_EN
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (rst_i || alloc_mask[l] || dlv_mask[l]) idle_cnt_q[l] <= '0;
      else if (lane_vld_q[l])                    idle_cnt_q[l] <= sat_inc(idle_cnt_q[l]);
    end
  end
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = (IDLE_CYCLES > 0) ^ (^dlv_mask) ^ (^alloc_mask);
`endif

endmodule

// File: tb/tb_rm_event_dispatcher.sv
// Directed self-checking bench for rm_event_dispatcher (default parameters, IDLE_CYCLES=16).
module tb_rm_event_dispatcher;

  localparam int NL = 5;
  localparam int NE = 10;
  localparam int NI = 2;
  localparam int CW = 16;
  localparam int EW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i, valid_i, ready_o;
  logic [CW-1:0]     ctx_i;
  logic [NI-1:0]     ins_valid_i;
  logic [NI*EW-1:0]  ins_event_i;
  logic              release_valid_i, release_ready_o;
  logic [CW-1:0]     release_ctx_i;
  logic [NL*NI*NE-1:0] lane_vector_o;
  logic [NL-1:0]     lane_reset_o, lane_ctx_valid_o;
  logic              evict_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic seen;

  rm_event_dispatcher #(.IDLE_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ctx_i(ctx_i), .ins_valid_i(ins_valid_i), .ins_event_i(ins_event_i),
    .release_valid_i(release_valid_i), .release_ready_o(release_ready_o),
    .release_ctx_i(release_ctx_i), .lane_vector_o(lane_vector_o),
    .lane_reset_o(lane_reset_o), .lane_ctx_valid_o(lane_ctx_valid_o), .evict_o(evict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ev_bit(input int lane, input int slot, input int ev);
    logic [127:0] one;
    one = 128'd1;
    return one << (lane*NI*NE + slot*NE + ev);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_vec"}, 128'(lane_vector_o), 128'd0);
    check({tag, "_rst"}, 128'(lane_reset_o), 128'd0);
    check({tag, "_evict"}, 128'(evict_o), 128'd0);
  endtask

  // Allocate a miss context with a single event 0 on slot 0
  task automatic alloc_ctx(input logic [CW-1:0] c, input int lane, input logic exp_evict);
    valid_i = 1'b1; ctx_i = c; ins_valid_i = 2'b01; ins_event_i = 8'h00;
    tick;
    valid_i = 1'b0;
    check("alloc_lane_reset", 128'(lane_reset_o), 128'd1 << lane);
    check("alloc_evict", 128'(evict_o), 128'(exp_evict));
    check("alloc_ready", 128'(ready_o), 128'd0);
    tick;
    check("alloc_deliver", 128'(lane_vector_o), ev_bit(lane, 0, 0));
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ctx_i = '0; ins_valid_i = '0; ins_event_i = '0;
    release_valid_i = 1'b0; release_ctx_i = '0;
    tick; tick;
    check("rst_ready", 128'(ready_o), 128'd0);
    check("rst_rel_ready", 128'(release_ready_o), 128'd0);
    check("rst_ctx_valid", 128'(lane_ctx_valid_o), 128'd0);
    check_quiet("rst");
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 128'(ready_o), 128'd1);

    // First allocation into empty table
    valid_i = 1'b1; ctx_i = 16'h0005; ins_valid_i = 2'b01; ins_event_i = 8'h03;
    tick;
    valid_i = 1'b0;
    check("t1_lane_reset", 128'(lane_reset_o), 128'h01);
    check("t1_ready", 128'(ready_o), 128'd0);
    check("t1_vec_zero", 128'(lane_vector_o), 128'd0);
    check("t1_ctx_valid", 128'(lane_ctx_valid_o), 128'h01);
    tick;
    check("t1_vec", 128'(lane_vector_o), 128'h8);
    check("t1_no_rst", 128'(lane_reset_o), 128'd0);
    check("t1_ready_back", 128'(ready_o), 128'd1);

    // Hit path, two groups back to back
    valid_i = 1'b1; ctx_i = 16'h0005; ins_valid_i = 2'b11; ins_event_i = 8'h09;
    tick;
    ins_valid_i = 2'b10; ins_event_i = 8'h50;
    check("hit1_vec", 128'(lane_vector_o), 128'h600);
    check("hit1_no_rst", 128'(lane_reset_o), 128'd0);
    check("hit1_ready", 128'(ready_o), 128'd1);
    tick;
    valid_i = 1'b0;
    check("hit2_vec", 128'(lane_vector_o), 128'h8000);
    tick;
    check_quiet("hit_idle");

    // Fill all lanes, then round-robin eviction
    rst_i = 1'b1; tick; rst_i = 1'b0;
    for (int i = 0; i < NL; i++) alloc_ctx(CW'(i + 1), i, 1'b0);
    check("full_ctx_valid", 128'(lane_ctx_valid_o), 128'h1f);
    alloc_ctx(16'd6, 0, 1'b1);
    alloc_ctx(16'd7, 1, 1'b1);
    valid_i = 1'b1; ctx_i = 16'd6; ins_valid_i = 2'b01; ins_event_i = 8'h02;
    tick;
    valid_i = 1'b0;
    check("ctx6_hit_vec", 128'(lane_vector_o), ev_bit(0, 0, 2));
    check("ctx6_hit_no_rst", 128'(lane_reset_o), 128'd0);

    // Release takes priority over a pending group
    release_valid_i = 1'b1; release_ctx_i = 16'd3;
    valid_i = 1'b1; ctx_i = 16'd8; ins_valid_i = 2'b01; ins_event_i = 8'h00;
    #1;
    check("rel_ready_blocked", 128'(ready_o), 128'd0);
    check("rel_ready", 128'(release_ready_o), 128'd1);
    tick;
    release_valid_i = 1'b0;
    check("rel_pulse", 128'(lane_reset_o), 128'h04);
    check("rel_ctx_valid", 128'(lane_ctx_valid_o), 128'h1b);
    check("rel_vec", 128'(lane_vector_o), 128'd0);
    tick;
    valid_i = 1'b0;
    check("rel_realloc_rst", 128'(lane_reset_o), 128'h04);
    check("rel_realloc_evict", 128'(evict_o), 128'd0);
    tick;
    check("rel_realloc_vec", 128'(lane_vector_o), ev_bit(2, 0, 0));
    check("rel_realloc_valid", 128'(lane_ctx_valid_o), 128'h1f);

    // Unknown context release
    release_valid_i = 1'b1; release_ctx_i = 16'h0099;
    tick;
    release_valid_i = 1'b0;
    check_quiet("rel_unknown");
    check("rel_unknown_valid", 128'(lane_ctx_valid_o), 128'h1f);

    // Out-of-range event index on slot 0
    valid_i = 1'b1; ctx_i = 16'd8; ins_valid_i = 2'b11; ins_event_i = 8'h1C;
    tick;
    valid_i = 1'b0;
    check("oor_vec", 128'(lane_vector_o), ev_bit(2, 1, 1));

    // Empty group on a missing context
    valid_i = 1'b1; ctx_i = 16'h0077; ins_valid_i = 2'b00;
    tick;
    valid_i = 1'b0;
    check_quiet("empty");
    check("empty_ready", 128'(ready_o), 128'd1);
    check("empty_valid", 128'(lane_ctx_valid_o), 128'h1f);

    // Reset while in RESET state drops the held group
    valid_i = 1'b1; ctx_i = 16'h0042; ins_valid_i = 2'b01; ins_event_i = 8'h04;
    tick;
    valid_i = 1'b0;
    check("mid_evict", 128'(evict_o), 128'd1);
    check("mid_lane_reset", 128'(lane_reset_o), 128'h04);
    rst_i = 1'b1;
    tick;
    check_quiet("mid_rst");
    check("mid_rst_valid", 128'(lane_ctx_valid_o), 128'd0);
    check("mid_rst_ready", 128'(ready_o), 128'd0);
    rst_i = 1'b0;
    tick;
    check_quiet("mid_after");
    alloc_ctx(16'h0042, 0, 1'b0);

    // Idle behaviour of the single allocated lane
    seen = 1'b0;
`ifdef RM_DISPATCH_IDLE_EVICT_EN
    for (int i = 0; i < 40 && !seen; i++) begin
      tick;
      seen = lane_reset_o[0];
    end
    check("idle_pulse_seen", 128'(seen), 128'd1);
    check("idle_ctx_valid", 128'(lane_ctx_valid_o), 128'd0);
`else
    for (int i = 0; i < 40; i++) begin
      tick;
      seen = seen | lane_reset_o[0];
    end
    check("idle_no_pulse", 128'(seen), 128'd0);
    check("idle_ctx_valid", 128'(lane_ctx_valid_o), 128'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
